// File: rtl/fifo_rd_fwft.sv
// Read-side controller for the async FIFO: owns the read pointer and empty flag,
// and presents memory data through a first-word-fall-through output register.
module fifo_rd_fwft #(
    parameter int DATASIZE = 32,
    parameter int ADDRSIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [ADDRSIZE:0]   rcount
);

    logic [ADDRSIZE:0]   rbin_q, rbin_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic                rempty_q, rempty_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                fill;
    logic [ADDRSIZE:0]   wbin;

    // A word moves into the output register whenever memory has one and the
    // register is free or being drained on this same edge.
    assign fill = !rempty_q && (!dout_valid_q || dout_ready);

    always_comb begin
        rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, fill};
        rptr_d       = rbin_d ^ (rbin_d >> 1);
        rempty_d     = (rptr_d == rq2_wptr);
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (fill) begin
            dout_d       = rdata_mem;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rcount     = (wbin - rbin_q) + {{ADDRSIZE{1'b0}}, dout_valid_q};

endmodule
